// File: rtl/wb_stage.sv
// Writeback stage: load alignment, RF write select, HI/LO ownership,
// registered debug trace and retired-instruction counter.
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic             stall0,
  input  logic             wreg,
  input  logic [4:0]       regdst,
  input  logic [1:0]       result_sel,
  input  logic [3:0]       load_type,
  input  logic [3:0]       byte_valid,
  input  logic [31:0]      ALU_result,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      rf_rdata0_fw,
  input  logic [31:0]      rf_rdata1_fw,
  input  logic             SC_result_sel,
  input  logic [63:0]      MulDiv_result,
  input  logic             whi,
  input  logic             wlo,
  input  logic             hi_i_sel,
  input  logic             lo_i_sel,
  input  logic [31:0]      PC_plus4,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    LD_W  = 4'd0,
    LD_B  = 4'd1,
    LD_BU = 4'd2,
    LD_H  = 4'd3,
    LD_HU = 4'd4,
    LD_WL = 4'd5,
    LD_WR = 4'd6
  } load_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_LINK = 2'd2,
    RES_SC   = 2'd3
  } res_e;

  logic        done;
  logic        fire;
  logic [1:0]  off;
  logic [1:0]  inv_off;
  logic [31:0] pc;
  logic [31:0] shr_word;
  logic [31:0] lwl_word;
  logic [15:0] half;
  logic [31:0] merge_src;
  logic [31:0] merged;
  logic [31:0] load_data;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_next, lo_next;

  // done marks that the instruction held in MEM/WB has already committed.
  assign fire    = wb_valid & ~done;
  assign off     = ALU_result[1:0];
  assign inv_off = ~off;
  assign pc      = PC_plus4 - 32'd4;

  assign shr_word = mem_rdata >> {off, 3'b000};
  assign lwl_word = mem_rdata << {inv_off, 3'b000};
  assign half     = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    merge_src = (load_type == LD_WL) ? lwl_word : shr_word;
    merged    = '0;
    for (int unsigned i = 0; i < 4; i++)
      merged[8*i +: 8] = byte_valid[i] ? merge_src[8*i +: 8] : rf_rdata1_fw[8*i +: 8];
  end

  always_comb begin
    load_data = mem_rdata;
    case (load_e'(load_type))
      LD_B:    load_data = {{24{shr_word[7]}}, shr_word[7:0]};
      LD_BU:   load_data = {24'd0, shr_word[7:0]};
      LD_H:    load_data = {{16{half[15]}}, half};
      LD_HU:   load_data = {16'd0, half};
      LD_WL,
      LD_WR:   load_data = merged;
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    rf_wdata = ALU_result;
    case (res_e'(result_sel))
      RES_ALU:  rf_wdata = ALU_result;
      RES_LOAD: rf_wdata = load_data;
      RES_LINK: rf_wdata = PC_plus4 + 32'd4;
      RES_SC:   rf_wdata = {31'd0, SC_result_sel};
      default:  rf_wdata = ALU_result;
    endcase
  end

  assign rf_we    = fire & wreg & (regdst != 5'd0);
  assign rf_waddr = regdst;

  assign hi_next = hi_i_sel ? rf_rdata0_fw : MulDiv_result[63:32];
  assign lo_next = lo_i_sel ? rf_rdata0_fw : MulDiv_result[31:0];
  assign hi_o    = (fire & whi) ? hi_next : hi_q;
  assign lo_o    = (fire & wlo) ? lo_next : lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      done              <= 1'b0;
      hi_q              <= '0;
      lo_q              <= '0;
      debug_wb_pc       <= RESET_PC;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      retired_cnt       <= '0;
    end else begin
      if (!stall0)
        done <= 1'b0;
      else if (fire)
        done <= 1'b1;
      if (fire & whi)
        hi_q <= hi_next;
      if (fire & wlo)
        lo_q <= lo_next;
      debug_wb_rf_wen <= {4{rf_we}};
      if (fire) begin
        debug_wb_pc       <= pc;
        debug_wb_rf_wnum  <= regdst;
        debug_wb_rf_wdata <= rf_wdata;
        retired_cnt       <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage: table of single-cycle commits plus
// hand-written stall, HI/LO and reset-mid-stall sequences.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        stall0;
  logic        wreg;
  logic [4:0]  regdst;
  logic [1:0]  result_sel;
  logic [3:0]  load_type;
  logic [3:0]  byte_valid;
  logic [31:0] ALU_result;
  logic [31:0] mem_rdata;
  logic [31:0] rf_rdata0_fw;
  logic [31:0] rf_rdata1_fw;
  logic        SC_result_sel;
  logic [63:0] MulDiv_result;
  logic        whi, wlo, hi_i_sel, lo_i_sel;
  logic [31:0] PC_plus4;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] hi_o, lo_o;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retired_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_cnt = 0;

  wb_stage #(.RESET_PC(32'hBFC0_0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .stall0(stall0), .wreg(wreg),
    .regdst(regdst), .result_sel(result_sel), .load_type(load_type),
    .byte_valid(byte_valid), .ALU_result(ALU_result), .mem_rdata(mem_rdata),
    .rf_rdata0_fw(rf_rdata0_fw), .rf_rdata1_fw(rf_rdata1_fw),
    .SC_result_sel(SC_result_sel), .MulDiv_result(MulDiv_result),
    .whi(whi), .wlo(wlo), .hi_i_sel(hi_i_sel), .lo_i_sel(lo_i_sel),
    .PC_plus4(PC_plus4), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_o(hi_o), .lo_o(lo_o), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  lt;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] rt;
    logic [3:0]  bv;
    logic [31:0] pc4;
    logic        sc;
    logic        ewe;
    logic [31:0] ewd;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{4'd1, 2'd1, 5'd5,  1'b1, 32'h0000_1002, 32'h80FF_1234, 32'h0,         4'b0000, 32'hBFC0_0100, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vt[1]  = '{4'd5, 2'd1, 5'd6,  1'b1, 32'h0000_2001, 32'hAABB_CCDD, 32'h1122_3344, 4'b1100, 32'hBFC0_0104, 1'b0, 1'b1, 32'hCCDD_3344};
    vt[2]  = '{4'd4, 2'd1, 5'd7,  1'b1, 32'h0000_2002, 32'hAABB_CCDD, 32'h0,         4'b0000, 32'hBFC0_0108, 1'b0, 1'b1, 32'h0000_AABB};
    vt[3]  = '{4'd3, 2'd1, 5'd8,  1'b1, 32'h0000_2000, 32'hAABB_CCDD, 32'h0,         4'b0000, 32'hBFC0_010C, 1'b0, 1'b1, 32'hFFFF_CCDD};
    vt[4]  = '{4'd2, 2'd1, 5'd9,  1'b1, 32'h0000_2001, 32'hAABB_CCDD, 32'h0,         4'b0000, 32'hBFC0_0110, 1'b0, 1'b1, 32'h0000_00CC};
    vt[5]  = '{4'd0, 2'd1, 5'd10, 1'b1, 32'h0000_2000, 32'hAABB_CCDD, 32'h0,         4'b0000, 32'hBFC0_0114, 1'b0, 1'b1, 32'hAABB_CCDD};
    vt[6]  = '{4'd6, 2'd1, 5'd11, 1'b1, 32'h0000_2002, 32'hAABB_CCDD, 32'h1122_3344, 4'b0011, 32'hBFC0_0118, 1'b0, 1'b1, 32'h1122_AABB};
    vt[7]  = '{4'd7, 2'd1, 5'd12, 1'b1, 32'h0000_2003, 32'hAABB_CCDD, 32'h0,         4'b0000, 32'hBFC0_011C, 1'b0, 1'b1, 32'hAABB_CCDD};
    vt[8]  = '{4'd1, 2'd1, 5'd14, 1'b1, 32'h0000_3003, 32'h7A00_0000, 32'h0,         4'b0000, 32'hBFC0_0120, 1'b0, 1'b1, 32'h0000_007A};
    vt[9]  = '{4'd0, 2'd0, 5'd13, 1'b1, 32'h1234_5678, 32'hAABB_CCDD, 32'h0,         4'b0000, 32'hBFC0_0124, 1'b0, 1'b1, 32'h1234_5678};
    vt[10] = '{4'd0, 2'd2, 5'd31, 1'b1, 32'h0000_0000, 32'h0,         32'h0,         4'b0000, 32'hBFC0_0004, 1'b0, 1'b1, 32'hBFC0_0008};
    vt[11] = '{4'd0, 2'd3, 5'd2,  1'b1, 32'h0000_0000, 32'h0,         32'h0,         4'b0000, 32'hBFC0_0128, 1'b1, 1'b1, 32'h0000_0001};
    vt[12] = '{4'd0, 2'd0, 5'd0,  1'b1, 32'hDEAD_0000, 32'h0,         32'h0,         4'b0000, 32'hBFC0_012C, 1'b0, 1'b0, 32'hDEAD_0000};
    vt[13] = '{4'd0, 2'd0, 5'd3,  1'b0, 32'h0000_0055, 32'h0,         32'h0,         4'b0000, 32'hBFC0_0130, 1'b0, 1'b0, 32'h0000_0055};

    rst = 1'b1; wb_valid = 1'b0; stall0 = 1'b0; wreg = 1'b0; regdst = '0;
    result_sel = '0; load_type = '0; byte_valid = '0; ALU_result = '0;
    mem_rdata = '0; rf_rdata0_fw = '0; rf_rdata1_fw = '0; SC_result_sel = 1'b0;
    MulDiv_result = '0; whi = 1'b0; wlo = 1'b0; hi_i_sel = 1'b0; lo_i_sel = 1'b0;
    PC_plus4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc",    debug_wb_pc, 32'hBFC0_0000);
    chk("reset_wen",   debug_wb_rf_wen, 4'h0);
    chk("reset_wnum",  debug_wb_rf_wnum, 5'd0);
    chk("reset_wdata", debug_wb_rf_wdata, 32'h0);
    chk("reset_hi",    hi_o, 32'h0);
    chk("reset_lo",    lo_o, 32'h0);
    chk("reset_cnt",   retired_cnt, 32'h0);
    rst = 1'b0;

    // single-cycle commits from the table
    for (int i = 0; i < 14; i++) begin
      wb_valid = 1'b1; stall0 = 1'b0;
      load_type = vt[i].lt; result_sel = vt[i].rs; regdst = vt[i].rd; wreg = vt[i].wr;
      ALU_result = vt[i].alu; mem_rdata = vt[i].mem; rf_rdata1_fw = vt[i].rt;
      byte_valid = vt[i].bv; PC_plus4 = vt[i].pc4; SC_result_sel = vt[i].sc;
      #1;
      chk($sformatf("v%0d_we", i),    rf_we, vt[i].ewe);
      chk($sformatf("v%0d_waddr", i), rf_waddr, vt[i].rd);
      chk($sformatf("v%0d_wdata", i), rf_wdata, vt[i].ewd);
      tick();
      exp_cnt++;
      chk($sformatf("v%0d_trace_wen", i),   debug_wb_rf_wen, {4{vt[i].ewe}});
      chk($sformatf("v%0d_trace_wnum", i),  debug_wb_rf_wnum, vt[i].rd);
      chk($sformatf("v%0d_trace_wdata", i), debug_wb_rf_wdata, vt[i].ewd);
      chk($sformatf("v%0d_trace_pc", i),    debug_wb_pc, vt[i].pc4 - 32'd4);
      chk($sformatf("v%0d_cnt", i),         retired_cnt, exp_cnt);
    end

    // bubble: nothing commits
    wb_valid = 1'b0; wreg = 1'b1; regdst = 5'd9;
    #1;
    chk("bubble_we", rf_we, 1'b0);
    tick();
    chk("bubble_cnt", retired_cnt, exp_cnt);
    chk("bubble_wen", debug_wb_rf_wen, 4'h0);
    chk("bubble_pc",  debug_wb_pc, 32'hBFC0_012C);

    // MULT writes both halves, visible same cycle
    wb_valid = 1'b1; wreg = 1'b0; whi = 1'b1; wlo = 1'b1; hi_i_sel = 1'b0; lo_i_sel = 1'b0;
    MulDiv_result = 64'h0000_0001_FFFF_FFFE;
    #1;
    chk("mult_hi_bypass", hi_o, 32'h0000_0001);
    chk("mult_lo_bypass", lo_o, 32'hFFFF_FFFE);
    tick();
    exp_cnt++;
    // bubble carrying write strobes must not touch HI/LO
    wb_valid = 1'b0; MulDiv_result = 64'h0;
    #1;
    chk("mult_hi_stored", hi_o, 32'h0000_0001);
    chk("mult_lo_stored", lo_o, 32'hFFFF_FFFE);
    tick();
    chk("bubble_hi_hold", hi_o, 32'h0000_0001);
    chk("bubble_lo_hold", lo_o, 32'hFFFF_FFFE);
    chk("mult_cnt", retired_cnt, exp_cnt);

    // MTLO from rs
    wb_valid = 1'b1; whi = 1'b0; wlo = 1'b1; lo_i_sel = 1'b1; rf_rdata0_fw = 32'd7;
    #1;
    chk("mtlo_lo_bypass", lo_o, 32'd7);
    chk("mtlo_hi_same",   hi_o, 32'h0000_0001);
    tick();
    exp_cnt++;
    wb_valid = 1'b0; wlo = 1'b0; lo_i_sel = 1'b0;
    #1;
    chk("mtlo_lo_stored", lo_o, 32'd7);
    chk("mtlo_hi_stored", hi_o, 32'h0000_0001);

    // instruction held three cycles by stall0
    wb_valid = 1'b1; stall0 = 1'b1; wreg = 1'b1; regdst = 5'd4; result_sel = 2'd0;
    ALU_result = 32'h44; PC_plus4 = 32'hBFC0_0200;
    #1;
    chk("stall_c1_we", rf_we, 1'b1);
    tick();
    exp_cnt++;
    chk("stall_c1_wen", debug_wb_rf_wen, 4'hF);
    chk("stall_c1_cnt", retired_cnt, exp_cnt);
    #1;
    chk("stall_c2_we", rf_we, 1'b0);
    tick();
    chk("stall_c2_wen", debug_wb_rf_wen, 4'h0);
    chk("stall_c2_cnt", retired_cnt, exp_cnt);
    stall0 = 1'b0;
    #1;
    chk("stall_c3_we", rf_we, 1'b0);
    tick();
    chk("stall_c3_wen", debug_wb_rf_wen, 4'h0);
    chk("stall_c3_cnt", retired_cnt, exp_cnt);
    chk("stall_c3_pc",  debug_wb_pc, 32'hBFC0_01FC);

    // bubble under stall leaves done clear
    wb_valid = 1'b0; stall0 = 1'b1;
    #1;
    chk("bstall_we", rf_we, 1'b0);
    tick();
    wb_valid = 1'b1; stall0 = 1'b0; ALU_result = 32'h66;
    #1;
    chk("after_bstall_we", rf_we, 1'b1);
    tick();
    exp_cnt++;
    chk("after_bstall_cnt",   retired_cnt, exp_cnt);
    chk("after_bstall_wdata", debug_wb_rf_wdata, 32'h66);

    // reset mid-stall on a JAL: held instruction re-commits once
    stall0 = 1'b1; regdst = 5'd31; result_sel = 2'd2; PC_plus4 = 32'hBFC0_0004;
    #1;
    chk("jal_we",    rf_we, 1'b1);
    chk("jal_wdata", rf_wdata, 32'hBFC0_0008);
    tick();
    rst = 1'b1;
    tick();
    exp_cnt = 0;
    chk("rst_mid_hi",  hi_o, 32'h0);
    chk("rst_mid_lo",  lo_o, 32'h0);
    chk("rst_mid_cnt", retired_cnt, exp_cnt);
    chk("rst_mid_pc",  debug_wb_pc, 32'hBFC0_0000);
    chk("rst_mid_wen", debug_wb_rf_wen, 4'h0);
    rst = 1'b0;
    #1;
    chk("rerun_we", rf_we, 1'b1);
    tick();
    exp_cnt++;
    chk("rerun_cnt",   retired_cnt, exp_cnt);
    chk("rerun_wen",   debug_wb_rf_wen, 4'hF);
    chk("rerun_pc",    debug_wb_pc, 32'hBFC0_0000);
    chk("rerun_wdata", debug_wb_rf_wdata, 32'hBFC0_0008);
    stall0 = 1'b0;
    #1;
    chk("rerun_held_we", rf_we, 1'b0);
    tick();
    chk("rerun_held_cnt", retired_cnt, exp_cnt);
    chk("rerun_held_wen", debug_wb_rf_wen, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage that consumes the MEM/WB pipeline register outputs.
- Aligns and extends load data, selects the register-file write value, owns the architectural HI/LO registers, and drives the RF write port.
- Emits a registered NSCSCC debug trace and a retired-instruction counter.
- Guarantees each instruction commits exactly once while MEM/WB is held by stall.

Parameters:
- RESET_PC, 32'hBFC0_0000, value of debug_wb_pc after reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  MEM/WB holds a live instruction (0 after flush or bubble).
- stall0  in  1  MEM/WB held next cycle; same instruction is presented again.
- wreg  in  1  instruction writes the RF.
- regdst  in  5  destination GPR.
- result_sel  in  2  RF write source: 0 ALU, 1 load, 2 link, 3 SC flag.
- load_type  in  4  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR; other values are treated as LW.
- byte_valid  in  4  per-byte merge mask for LWL/LWR (1 = byte taken from memory).
- ALU_result  in  32  ALU result and effective address.
- mem_rdata  in  32  raw aligned data word from memory.
- rf_rdata0_fw  in  32  rs value (MTHI/MTLO source).
- rf_rdata1_fw  in  32  rt old value (LWL/LWR merge base).
- SC_result_sel  in  1  SC success flag.
- MulDiv_result  in  64  {hi, lo} from mul/div.
- whi, wlo  in  1  write HI / write LO.
- hi_i_sel, lo_i_sel  in  1  1 = source rf_rdata0_fw, 0 = MulDiv half.
- PC_plus4  in  32  PC of instruction + 4.
- rf_we  out  1  RF write enable (combinational).
- rf_waddr  out  5  RF write address (combinational).
- rf_wdata  out  32  RF write data (combinational; also the forwarding source).
- hi_o, lo_o  out  32  HI/LO with same-cycle bypass of a committing write.
- debug_wb_pc  out  32  registered trace PC.
- debug_wb_rf_wen  out  4  registered trace write enable, 4'hF or 4'h0.
- debug_wb_rf_wnum  out  5  registered trace register number.
- debug_wb_rf_wdata  out  32  registered trace write data.
- retired_cnt  out  CNT_W  count of committed instructions.

Behaviour:
- Commit control:
  - fire = wb_valid & ~done.
  - done is a flop: set when fire & stall0, cleared when ~stall0; reset to 0.
  - While MEM/WB is stalled, the instruction fires in its first cycle only.
- Address offset and PC: off = ALU_result[1:0]; pc = PC_plus4 - 4.
- Load data, with w = mem_rdata >> (8*off):
  - LB/LBU: sign/zero-extend w[7:0].
  - LH/LHU: use mem_rdata[31:16] if off[1] else [15:0], sign/zero-extended.
  - LW: mem_rdata.
  - LWL: m = mem_rdata << (8*(3-off)).
  - LWR: m = mem_rdata >> (8*off).
  - LWL/LWR result: byte i = byte_valid[i] ? m[i] : rf_rdata1_fw[i].
- result_sel values:
  - 0: ALU_result.
  - 1: load data.
  - 2: PC_plus4 + 4 (link address).
  - 3: {31'b0, SC_result_sel}.
- RF write port: rf_we = fire & wreg & (regdst != 0); rf_waddr = regdst; rf_wdata = selected result.
- HI/LO registers:
  - On fire & whi: hi <= hi_i_sel ? rf_rdata0_fw : MulDiv_result[63:32].
  - On fire & wlo: lo <= lo_i_sel ? rf_rdata0_fw : MulDiv_result[31:0].
  - Both reset to 0.
  - hi_o/lo_o return the value being written this cycle when the matching write fires, otherwise the stored value.
- Debug trace (one-cycle latency, registered every cycle):
  - debug_wb_pc <= fire ? pc : hold.
  - debug_wb_rf_wen <= {4{rf_we}}.
  - debug_wb_rf_wnum <= fire ? regdst : hold.
  - debug_wb_rf_wdata <= fire ? rf_wdata : hold.
  - Reset values: RESET_PC, 0, 0, 0.
- retired_cnt: increments by 1 on fire and wraps at 2^CNT_W; reset to 0.
- Simultaneous events:
  - whi & wlo in the same fire update both registers.
  - A bubble (wb_valid=0) with stall0=1 leaves done=0.
  - rst mid-stall clears done, so the held instruction fires again once rst deasserts.
- No internal combinational path from stall0 to rf_we other than through the done flop.

Test Plan:
- LB, ALU_result=...02, mem_rdata=32'h80FF_1234, result_sel=1, regdst=5 -> rf_we=1, rf_wdata=32'hFFFF_FFFF; next cycle debug_wb_rf_wen=4'hF, wnum=5.
- LWL, off=1, byte_valid=4'b1100, mem_rdata=32'hAABB_CCDD, rf_rdata1_fw=32'h1122_3344 -> rf_wdata=32'hCCDD_3344. LHU with off=2 and the same mem_rdata -> 32'h0000_AABB.
- MULT commit, whi=wlo=1, sel=0, MulDiv_result=64'h1_FFFF_FFFE -> hi_o=1 and lo_o=32'hFFFF_FFFE in the same cycle, stored on the next edge. Then MTLO with rs=7 -> lo=7, hi unchanged.
- Instruction held 3 cycles by stall0 -> rf_we high in cycle 1 only; retired_cnt +1; debug_wb_rf_wen pulses once.
- regdst=0 with wreg=1 -> rf_we=0, trace wen=0, retired_cnt still +1. wb_valid=0 -> no counter change.
- rst asserted mid-stall -> hi/lo=0, retired_cnt=0, debug_wb_pc=RESET_PC; after release the held instruction commits once. JAL with PC_plus4=32'hBFC0_0004, result_sel=2 -> rf_wdata=32'hBFC0_0008.
